// File: rtl/contador_pkg.sv
// Shared constants, a clog2 helper and the parameter-range check used by the modulo counter.
// The optional macro CONTADOR_UPDOWN_EN (consumed by the top) enables down counting.
package contador_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// Elaboration-time guard: width 1..16 and 2 <= modulo <= 2**width.
`define CONTADOR_CHECK_PARAMS(W, M) \
    if ((W) < 1 || (W) > 16 || (M) < 2 || (M) > (2 ** (W))) begin : g_param_err \
        $error("modulo_contador_t: illegal WIDTH/MODULO combination"); \
    end

// File: rtl/celula_ff_t.sv
// One-bit T flip-flop cell: falling-edge, synchronous active-high clear.
module celula_ff_t (
    input  logic clk,
    input  logic clr,
    input  logic t_i,
    output logic q_i,
    output logic q_bar_i
);

    always_ff @(negedge clk) begin
        if (clr) begin
            q_i <= 1'b0;
        end else if (t_i) begin
            q_i <= ~q_i;
        end
    end

    assign q_bar_i = ~q_i;

endmodule

// File: rtl/modulo_contador_t.sv
// Modulo-N counter built from per-bit T cells with clamped preset, cascade tc and wrap pulse.
// Define CONTADOR_UPDOWN_EN to honour up_down; otherwise the counter is up-only.
module modulo_contador_t
    import contador_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             prst,
    input  logic             enable,
    input  logic             t,
    input  logic             up_down,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    `CONTADOR_CHECK_PARAMS(WIDTH, MODULO)

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULO - 1);

    logic             at_terminal;
    logic             load_go;
    logic             count_go;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] toggle;

`ifdef CONTADOR_UPDOWN_EN
    logic dir_up;
    assign dir_up      = (up_down == DIR_UP);
    assign at_terminal = dir_up ? (q == TOP_VAL) : (q == '0);
`else
    logic unused_up_down;
    assign unused_up_down = up_down;
    assign at_terminal    = (q == TOP_VAL);
`endif

    // prst without enable holds; it must not fall through to counting.
    assign load_go  = prst & enable;
    assign count_go = enable & t & ~prst;

    always_comb begin
        next_val = q;
        if (load_go) begin
            next_val = (d > TOP_VAL) ? TOP_VAL : d;
        end else if (count_go) begin
`ifdef CONTADOR_UPDOWN_EN
            if (dir_up) begin
                next_val = at_terminal ? '0 : q + 1'b1;
            end else begin
                next_val = at_terminal ? TOP_VAL : q - 1'b1;
            end
`else
            next_val = at_terminal ? '0 : q + 1'b1;
`endif
        end
    end

    // Each cell flips only where the next value differs; clr is applied inside the cells.
    assign toggle = q ^ next_val;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        celula_ff_t u_cell (
            .clk     (clk),
            .clr     (clr),
            .t_i     (toggle[i]),
            .q_i     (q[i]),
            .q_bar_i (q_bar[i])
        );
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            wrap <= 1'b0;
        end else begin
            wrap <= count_go & at_terminal;
        end
    end

    assign tc = enable & t & at_terminal;

endmodule

// File: tb/tb_modulo_contador_t.sv
// Directed self-checking bench for modulo_contador_t (WIDTH=4, MODULO=10), including a two-stage cascade.
module tb_modulo_contador_t;

    logic       clk = 1'b0;
    logic       clr, prst, enable, t, up_down;
    logic [3:0] d;
    logic [3:0] q, q_bar;
    logic       tc, wrap;

    logic       c_clr, c_t;
    logic [3:0] u_q, u_qb, n_q, n_qb;
    logic       u_tc, u_wrap, n_tc, n_wrap;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    modulo_contador_t #(.WIDTH(4), .MODULO(10)) dut (
        .clk(clk), .clr(clr), .prst(prst), .enable(enable), .t(t), .up_down(up_down),
        .d(d), .q(q), .q_bar(q_bar), .tc(tc), .wrap(wrap)
    );

    modulo_contador_t #(.WIDTH(4), .MODULO(10)) u_units (
        .clk(clk), .clr(c_clr), .prst(1'b0), .enable(1'b1), .t(c_t), .up_down(1'b1),
        .d(4'd0), .q(u_q), .q_bar(u_qb), .tc(u_tc), .wrap(u_wrap)
    );

    modulo_contador_t #(.WIDTH(4), .MODULO(10)) u_tens (
        .clk(clk), .clr(c_clr), .prst(1'b0), .enable(1'b1), .t(u_tc), .up_down(1'b1),
        .d(4'd0), .q(n_q), .q_bar(n_qb), .tc(n_tc), .wrap(n_wrap)
    );

    // Inputs change just after the rising edge; the DUT updates on the falling edge
    // in between, so results are stable by the following rising edge.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; prst = 1'b1; t = 1'b1; enable = 1'b0; up_down = 1'b1; d = 4'd7;
        c_clr = 1'b1; c_t = 1'b0;
        edge_step();
        clr = 1'b0; prst = 1'b0; t = 1'b0; c_clr = 1'b0;
        compared++;
        if (q !== 4'd0) begin mismatched++; $display("FAIL reset_q got %0d want 0", q); end
        compared++;
        if (q_bar !== 4'hF) begin mismatched++; $display("FAIL reset_q_bar got %h want f", q_bar); end
        compared++;
        if (wrap !== 1'b0) begin mismatched++; $display("FAIL reset_wrap got %b want 0", wrap); end
    endtask

    task automatic test_count_up();
        int exp_q;
        exp_q = 0;
        enable = 1'b1; t = 1'b1; up_down = 1'b1; prst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            compared++;
            if (tc !== (exp_q == 9)) begin
                mismatched++; $display("FAIL up_tc step %0d got %b want %b", i, tc, (exp_q == 9));
            end
            exp_q = (exp_q == 9) ? 0 : exp_q + 1;
            edge_step();
            compared++;
            if (q !== 4'(exp_q)) begin
                mismatched++; $display("FAIL up_q step %0d got %0d want %0d", i, q, exp_q);
            end
            compared++;
            if (wrap !== (i == 10)) begin
                mismatched++; $display("FAIL up_wrap step %0d got %b want %b", i, wrap, (i == 10));
            end
            compared++;
            if (q_bar !== ~4'(exp_q)) begin
                mismatched++; $display("FAIL up_q_bar step %0d got %h want %h", i, q_bar, ~4'(exp_q));
            end
        end
        t = 1'b0;
    endtask

    task automatic test_preset();
        enable = 1'b1; prst = 1'b1; t = 1'b0; d = 4'd13;
        edge_step();
        compared++;
        if (q !== 4'd9) begin mismatched++; $display("FAIL preset_clamp got %0d want 9", q); end
        d = 4'd5; t = 1'b1;
        edge_step();
        compared++;
        if (q !== 4'd5) begin mismatched++; $display("FAIL preset_load got %0d want 5", q); end
        compared++;
        if (wrap !== 1'b0) begin mismatched++; $display("FAIL preset_wrap got %b want 0", wrap); end
        enable = 1'b0; d = 4'd2; t = 1'b1;
        edge_step();
        edge_step();
        compared++;
        if (q !== 4'd5) begin mismatched++; $display("FAIL preset_hold got %0d want 5", q); end
        compared++;
        if (tc !== 1'b0) begin mismatched++; $display("FAIL preset_tc_disabled got %b want 0", tc); end
        prst = 1'b0; t = 1'b0;
    endtask

    task automatic test_direction();
        enable = 1'b1; prst = 1'b1; t = 1'b0;
`ifdef CONTADOR_UPDOWN_EN
        d = 4'd1;
        edge_step();
        prst = 1'b0; t = 1'b1; up_down = 1'b0;
        #1;
        compared++;
        if (tc !== 1'b0) begin mismatched++; $display("FAIL down_tc_at1 got %b want 0", tc); end
        edge_step();
        compared++;
        if (q !== 4'd0) begin mismatched++; $display("FAIL down_q0 got %0d want 0", q); end
        compared++;
        if (tc !== 1'b1) begin mismatched++; $display("FAIL down_tc_at0 got %b want 1", tc); end
        edge_step();
        compared++;
        if (q !== 4'd9) begin mismatched++; $display("FAIL down_q9 got %0d want 9", q); end
        compared++;
        if (wrap !== 1'b1) begin mismatched++; $display("FAIL down_wrap got %b want 1", wrap); end
        edge_step();
        compared++;
        if (q !== 4'd8) begin mismatched++; $display("FAIL down_q8 got %0d want 8", q); end
        compared++;
        if (wrap !== 1'b0) begin mismatched++; $display("FAIL down_wrap_clear got %b want 0", wrap); end
`else
        d = 4'd3;
        edge_step();
        prst = 1'b0; t = 1'b1; up_down = 1'b0;
        edge_step();
        compared++;
        if (q !== 4'd4) begin mismatched++; $display("FAIL uponly_q got %0d want 4", q); end
        prst = 1'b1; t = 1'b0; d = 4'd9;
        edge_step();
        prst = 1'b0; t = 1'b1;
        #1;
        compared++;
        if (tc !== 1'b1) begin mismatched++; $display("FAIL uponly_tc got %b want 1", tc); end
        edge_step();
        compared++;
        if (q !== 4'd0) begin mismatched++; $display("FAIL uponly_wrap_q got %0d want 0", q); end
`endif
        t = 1'b0; up_down = 1'b1;
    endtask

    task automatic test_clr_mid();
        enable = 1'b1; prst = 1'b1; t = 1'b0; d = 4'd9;
        edge_step();
        clr = 1'b1; prst = 1'b1; t = 1'b1; d = 4'd4;
        edge_step();
        clr = 1'b0; prst = 1'b0; t = 1'b0;
        compared++;
        if (q !== 4'd0) begin mismatched++; $display("FAIL clr_mid_q got %0d want 0", q); end
        compared++;
        if (wrap !== 1'b0) begin mismatched++; $display("FAIL clr_mid_wrap got %b want 0", wrap); end
    endtask

    task automatic test_cascade();
        c_clr = 1'b1; c_t = 1'b0;
        edge_step();
        c_clr = 1'b0; c_t = 1'b1;
        for (int i = 0; i < 25; i++) begin
            edge_step();
        end
        c_t = 1'b0;
        compared++;
        if (u_q !== 4'd5) begin mismatched++; $display("FAIL cascade_units got %0d want 5", u_q); end
        compared++;
        if (n_q !== 4'd2) begin mismatched++; $display("FAIL cascade_tens got %0d want 2", n_q); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_preset();
        test_direction();
        test_clr_mid();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
